// File: rtl/noc_flit_parser_if.sv
// rtl/noc_flit_parser_if.sv - flit input, body FIFO and descriptor bundle for noc_flit_parser
// slave is the parser's view; master is the flit source / AXI-side consumer.
interface noc_flit_parser_if #(
    parameter int DATA_WIDTH     = 128,
    parameter int ID_WIDTH       = 4,
    parameter int VIRTUAL_CH_NUM = 16,
    parameter int AXI_ADDR_WIDTH = 32
);
    logic [DATA_WIDTH:0]         noc2axi_data;
    logic                        s_is_head;
    logic                        s_is_tail;
    logic                        nsu_busy;
    logic                        body_valid;
    logic                        body_ready;
    logic [DATA_WIDTH-1:0]       body_data;
    logic                        desc_valid;
    logic                        desc_ready;
    logic [ID_WIDTH-1:0]         desc_src;
    logic [VIRTUAL_CH_NUM-1:0]   desc_pack_order;
    logic [VIRTUAL_CH_NUM-1:0]   desc_pack_num;
    logic [7:0]                  desc_len;
    logic [AXI_ADDR_WIDTH-1:0]   desc_addr;
    logic [AXI_ADDR_WIDTH-1:0]   desc_re_pack;
    logic [4:0]                  desc_body_cnt;
    logic [4:0]                  desc_err;
    logic                        sts_proto_err;
    logic                        sts_ovf;

    modport slave (
        input  noc2axi_data, s_is_head, s_is_tail, body_ready, desc_ready,
        output nsu_busy, body_valid, body_data, desc_valid, desc_src,
               desc_pack_order, desc_pack_num, desc_len, desc_addr,
               desc_re_pack, desc_body_cnt, desc_err, sts_proto_err, sts_ovf
    );

    modport master (
        output noc2axi_data, s_is_head, s_is_tail, body_ready, desc_ready,
        input  nsu_busy, body_valid, body_data, desc_valid, desc_src,
               desc_pack_order, desc_pack_num, desc_len, desc_addr,
               desc_re_pack, desc_body_cnt, desc_err, sts_proto_err, sts_ovf
    );
endinterface

// File: rtl/noc_flit_parser.sv
// rtl/noc_flit_parser.sv - NoC write-path flit parser with body FIFO and packet descriptor
// Head/body/tail framing FSM, FWFT body FIFO, one descriptor per accepted tail.
module noc_flit_parser #(
    parameter int                DATA_WIDTH     = 128,
    parameter int                ID_WIDTH       = 4,
    parameter int                VIRTUAL_CH_NUM = 16,
    parameter int                AXI_ADDR_WIDTH = 32,
    parameter int                FLIT_NUM_MAX   = 16,
    parameter logic [2:0]        TYPE_WRITE     = 3'b100,
    parameter logic [3:0]        HEAD_CODE_H    = 4'h5,
    parameter logic [3:0]        HEAD_CODE_E    = 4'hA,
    parameter logic [3:0]        TAIL_CODE_H    = 4'h0,
    parameter logic [3:0]        TAIL_CODE_E    = 4'hF,
    parameter logic [ID_WIDTH-1:0] LOCAL_ID     = 4'hF,
    parameter int                FIFO_DEPTH     = 4
) (
    input  logic             noc_clk,
    input  logic             noc_rst,
    noc_flit_parser_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_LVL = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] BUSY_LVL = CW'(FIFO_DEPTH - 1);

    localparam int CH_MSB  = DATA_WIDTH - 1;
    localparam int SRC_MSB = CH_MSB - 4;
    localparam int DST_MSB = SRC_MSB - ID_WIDTH;
    localparam int TYP_MSB = DST_MSB - ID_WIDTH;
    localparam int VC_MSB  = TYP_MSB - 3;
    localparam int LEN_MSB = VC_MSB - VIRTUAL_CH_NUM;
    localparam int ADR_MSB = LEN_MSB - 8;
    localparam int CE_MSB  = ADR_MSB - AXI_ADDR_WIDTH;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BODY = 1'b1;

    logic                      flit_v;
    logic [DATA_WIDTH-1:0]     pl;
    logic [3:0]                f_ch, f_ce;
    logic [ID_WIDTH-1:0]       f_src, f_dst;
    logic [2:0]                f_typ;
    logic [VIRTUAL_CH_NUM-1:0] f_vc;
    logic [7:0]                f_len;
    logic [AXI_ADDR_WIDTH-1:0] f_adr;
    logic                      is_head, is_tail, is_body, is_both;

    assign flit_v = bus.noc2axi_data[DATA_WIDTH];
    assign pl     = bus.noc2axi_data[DATA_WIDTH-1:0];
    assign f_ch   = pl[CH_MSB  -: 4];
    assign f_src  = pl[SRC_MSB -: ID_WIDTH];
    assign f_dst  = pl[DST_MSB -: ID_WIDTH];
    assign f_typ  = pl[TYP_MSB -: 3];
    assign f_vc   = pl[VC_MSB  -: VIRTUAL_CH_NUM];
    assign f_len  = pl[LEN_MSB -: 8];
    assign f_adr  = pl[ADR_MSB -: AXI_ADDR_WIDTH];
    assign f_ce   = pl[CE_MSB  -: 4];

    assign is_head = flit_v &&  bus.s_is_head && !bus.s_is_tail;
    assign is_tail = flit_v && !bus.s_is_head &&  bus.s_is_tail;
    assign is_body = flit_v && !bus.s_is_head && !bus.s_is_tail;
    assign is_both = flit_v &&  bus.s_is_head &&  bus.s_is_tail;

    logic [0:0]                state_q, state_d;
    logic [4:0]                cnt_q, cnt_d;
    logic                      proto_q, proto_d;
    logic                      ovf_q, ovf_d;
    logic                      busy_q, busy_d;
    logic                      head_load, push, pop, desc_load;

    logic [ID_WIDTH-1:0]       hd_src_q, hd_dst_q;
    logic [2:0]                hd_typ_q;
    logic [VIRTUAL_CH_NUM-1:0] hd_order_q;
    logic [7:0]                hd_len_q;
    logic [AXI_ADDR_WIDTH-1:0] hd_addr_q;
    logic                      hd_code_err_q, hd_dst_err_q;

    logic [DATA_WIDTH-1:0]     mem_q [FIFO_DEPTH];
    logic [PW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]             count_q, count_d;
    logic                      fifo_full, fifo_nempty;

    logic                      desc_valid_q, desc_valid_d;
    logic [ID_WIDTH-1:0]       desc_src_q;
    logic [VIRTUAL_CH_NUM-1:0] desc_order_q, desc_num_q;
    logic [7:0]                desc_len_q;
    logic [AXI_ADDR_WIDTH-1:0] desc_addr_q, desc_re_pack_q;
    logic [4:0]                desc_cnt_q, desc_err_q;
    logic                      desc_busy;

    logic                      t_code_err, t_field_err, t_cnt_err;
    logic [4:0]                exp_cnt;

    assign fifo_full   = (count_q == FULL_LVL);
    assign fifo_nempty = (count_q != '0);
    assign pop         = fifo_nempty && bus.body_ready;
    assign desc_busy   = desc_valid_q && !bus.desc_ready;

    // Tail checks compare the tail flit against the latched head fields.
    assign t_code_err  = (f_ch != TAIL_CODE_H) || (f_ce != TAIL_CODE_E);
    assign t_field_err = (f_src != hd_src_q) || (f_dst != hd_dst_q) ||
                         (f_typ != hd_typ_q) || (f_len != hd_len_q) ||
                         (hd_typ_q != TYPE_WRITE);
    assign exp_cnt     = (hd_order_q != f_vc) ? 5'(FLIT_NUM_MAX)
                                              : 5'(hd_len_q[3:0]) + 5'd1;
    assign t_cnt_err   = (cnt_q != exp_cnt);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        proto_d   = proto_q;
        ovf_d     = ovf_q;
        head_load = 1'b0;
        push      = 1'b0;
        desc_load = 1'b0;
        if (is_both) begin
            proto_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (is_head) begin
                        head_load = 1'b1;
                        cnt_d     = '0;
                        state_d   = S_BODY;
                    end else if (is_body || is_tail) begin
                        proto_d = 1'b1;
                    end
                end
                default: begin
                    if (is_head) begin
                        // Abandon the open packet and restart framing from this head.
                        proto_d   = 1'b1;
                        head_load = 1'b1;
                        cnt_d     = '0;
                    end else if (is_body) begin
                        if (cnt_q != 5'd31) cnt_d = cnt_q + 5'd1;
                        if (fifo_full) ovf_d = 1'b1;
                        else           push  = 1'b1;
                    end else if (is_tail) begin
                        state_d = S_IDLE;
                        if (desc_busy) ovf_d     = 1'b1;
                        else           desc_load = 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (!push && pop) count_d = count_q - CW'(1);
        desc_valid_d = desc_load || desc_busy;
        busy_d       = (count_d >= BUSY_LVL) || desc_valid_d;
    end

    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            proto_q        <= 1'b0;
            ovf_q          <= 1'b0;
            busy_q         <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            hd_src_q       <= '0;
            hd_dst_q       <= '0;
            hd_typ_q       <= '0;
            hd_order_q     <= '0;
            hd_len_q       <= '0;
            hd_addr_q      <= '0;
            hd_code_err_q  <= 1'b0;
            hd_dst_err_q   <= 1'b0;
            desc_valid_q   <= 1'b0;
            desc_src_q     <= '0;
            desc_order_q   <= '0;
            desc_num_q     <= '0;
            desc_len_q     <= '0;
            desc_addr_q    <= '0;
            desc_re_pack_q <= '0;
            desc_cnt_q     <= '0;
            desc_err_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            proto_q      <= proto_d;
            ovf_q        <= ovf_d;
            busy_q       <= busy_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            desc_valid_q <= desc_valid_d;
            if (head_load) begin
                hd_src_q      <= f_src;
                hd_dst_q      <= f_dst;
                hd_typ_q      <= f_typ;
                hd_order_q    <= f_vc;
                hd_len_q      <= f_len;
                hd_addr_q     <= f_adr;
                hd_code_err_q <= (f_ch != HEAD_CODE_H) || (f_ce != HEAD_CODE_E);
                hd_dst_err_q  <= (f_dst != LOCAL_ID);
            end
            if (desc_load) begin
                desc_src_q     <= hd_src_q;
                desc_order_q   <= hd_order_q;
                desc_num_q     <= f_vc;
                desc_len_q     <= hd_len_q;
                desc_addr_q    <= hd_addr_q;
                desc_re_pack_q <= f_adr;
                desc_cnt_q     <= cnt_q;
                desc_err_q     <= {hd_dst_err_q, t_cnt_err, t_field_err,
                                   t_code_err, hd_code_err_q};
            end
        end
    end

    // Storage needs no reset: nothing reads it until the pointers say it was written.
    always_ff @(posedge noc_clk) begin
        if (push) mem_q[wr_ptr_q] <= pl;
    end

    assign bus.nsu_busy        = busy_q;
    assign bus.body_valid      = fifo_nempty;
    assign bus.body_data       = fifo_nempty ? mem_q[rd_ptr_q] : '0;
    assign bus.desc_valid      = desc_valid_q;
    assign bus.desc_src        = desc_src_q;
    assign bus.desc_pack_order = desc_order_q;
    assign bus.desc_pack_num   = desc_num_q;
    assign bus.desc_len        = desc_len_q;
    assign bus.desc_addr       = desc_addr_q;
    assign bus.desc_re_pack    = desc_re_pack_q;
    assign bus.desc_body_cnt   = desc_cnt_q;
    assign bus.desc_err        = desc_err_q;
    assign bus.sts_proto_err   = proto_q;
    assign bus.sts_ovf         = ovf_q;
endmodule

// File: doc/noc_flit_parser.md
# noc_flit_parser

Receive-side flit parser for the NoC write path: consumes head/body/tail flits on the `noc2axi_data` / `s_is_head` / `s_is_tail` interface, validates framing codes and header/tail consistency, and buffers body flits in a small FIFO toward the AXI write master. It drives `nsu_busy` back to the flit source and emits one packet descriptor per tail with error flags. It sits at the NoC-facing edge of the NSU, in front of the AXI write engine.

## Interface
- DATA_WIDTH, 128, flit payload width
- ID_WIDTH, 4, source/destination ID width
- VIRTUAL_CH_NUM, 16, one-hot pack_order / pack_num width
- AXI_ADDR_WIDTH, 32, address / re_pack field width
- FLIT_NUM_MAX, 16, body flits in every non-final packet
- TYPE_WRITE, 3'b100, expected TYPE
- HEAD_CODE_H / HEAD_CODE_E, 4'h5 / 4'hA, head framing codes (4 bits each)
- TAIL_CODE_H / TAIL_CODE_E, 4'h0 / 4'hF, tail framing codes (4 bits each)
- LOCAL_ID, 4'hF, this node's ID
- FIFO_DEPTH, 4, body FIFO entries (power of 2, ≥4)

Ports:
- noc_clk  in  1  sole clock
- noc_rst  in  1  asynchronous, active-high reset
- noc2axi_data  in  DATA_WIDTH+1  bit [DATA_WIDTH] = flit valid; [DATA_WIDTH-1:0] = payload
- s_is_head  in  1  flit is head
- s_is_tail  in  1  flit is tail
- nsu_busy  out  1  registered backpressure to the flit source
- body_valid / body_ready  out / in  1 / 1  body FIFO handshake (FWFT)
- body_data  out  DATA_WIDTH  FIFO head entry
- desc_valid / desc_ready  out / in  1 / 1  descriptor handshake
- desc_src  out  ID_WIDTH  head Source_ID
- desc_pack_order / desc_pack_num  out  VIRTUAL_CH_NUM  from head / tail
- desc_len  out  8  AXI_LEN from head
- desc_addr / desc_re_pack  out  AXI_ADDR_WIDTH  from head / tail
- desc_body_cnt  out  5  body flits received (saturates at 31)
- desc_err  out  5  [0] bad head code, [1] bad tail code, [2] head/tail SRC/DST/TYPE/LEN mismatch or TYPE≠TYPE_WRITE, [3] body-count mismatch, [4] DST≠LOCAL_ID
- sts_proto_err / sts_ovf  out  1 / 1  sticky flags; cleared only by reset

## Operation
- Field packing, MSB-first from bit DATA_WIDTH-1: CODE_H(4), SRC(ID), DST(ID), TYPE(3), ORDER/NUM(VC), LEN(8), ADDR/RE_PACK(AW), CODE_E(4). Remaining low bits are ignored.
- A flit is present only when bit DATA_WIDTH=1. Flags are ignored on non-valid flits.
- A valid flit with both s_is_head and s_is_tail set is dropped and sets sts_proto_err.
- FSM has two states, IDLE and BODY:
  - IDLE + head: latch fields, check codes (err[0], err[4]), clear the body counter, go to BODY.
  - IDLE + body or tail: drop the flit and set sts_proto_err.
  - BODY + body: push the payload into the FIFO and increment the counter (saturating).
  - BODY + tail: check codes and fields, compute err[3], load the descriptor, go to IDLE.
  - BODY + head: set sts_proto_err, discard the open packet (no descriptor; already-pushed bodies stay in the FIFO), and restart from the new head.
- Expected body count: FLIT_NUM_MAX if pack_order≠pack_num, otherwise LEN[3:0]+1.
- FIFO full when a body arrives: drop the flit and set sts_ovf; the counter still increments.
- Descriptor occupied (desc_valid && !desc_ready) when a tail arrives: drop the tail, set sts_ovf, and return to IDLE.
- A descriptor may be presented before its body flits drain from the FIFO.

## Timing
- Reset: all outputs are 0, FSM is IDLE, FIFO is empty. The reset takes effect immediately (asynchronous), including mid-packet.
- Flit → FIFO: a body sampled at edge N gives body_valid=1 after edge N (1-cycle latency).
- Tail → descriptor: a tail sampled at edge N gives desc_valid=1 after edge N. desc_valid holds, with fields stable, until the desc_ready cycle.
- FIFO push and pop in the same cycle are legal; the count is unchanged.
- nsu_busy is registered: nsu_busy <= (count_next ≥ FIFO_DEPTH-1) || desc_valid_next.
- The flit source reacts one cycle late, so one flit may arrive after busy rises; it must be accepted without loss.
- The counter is 5 bits, saturating; the comparison uses the 5-bit value.

## Test plan
- Nominal packet: head(ORDER=16'h0001, LEN=8'h29, ADDR=32'h2000), bodies 1..16, tail(NUM=16'h0004, RE_PACK=32'h0000407F), both ready=1 → body_data 1..16 in order; desc_body_cnt=16, desc_err=0.
- Final packet with ORDER=NUM=16'h0004: 10 bodies → err=0. Same packet with 9 bodies → err[3]=1.
- body_ready=0 for 20 cycles during a 16-body packet → nsu_busy=1 once count≥3. A generator honouring busy with 1-cycle lag loses nothing (sts_ovf=0), and the data sequence is intact after release.
- Head with CODE_E=4'h0 → err[0]. Tail with TYPE=3'b010 → err[2]. Head with DST=4'h3 → err[4].
- Body flit while IDLE → no push, sts_proto_err=1. Head during BODY → old packet gives no descriptor; the new packet completes normally.
- Assert noc_rst mid-packet after 5 bodies → body_valid, desc_valid and nsu_busy are 0 immediately. The next full packet parses cleanly.
